// File: rtl/mrd_pkg.sv
// mrd_pkg: shared constants, unloader state enum and signed saturation for the Mixed Radix DFT memory
package mrd_pkg;
    localparam int NUM_BANKS  = 7;
    localparam int BANK_AW    = 8;
    localparam int DFT_MAXPTS = 1792;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} src_state_e;

    function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (x > hi) ? hi : (x < lo) ? lo : x;
    endfunction
endpackage

// File: rtl/mrd_st_if.sv
// mrd_st_if: streaming sample interface with sop/eop framing
interface mrd_st_if #(parameter int wOut = 18);
    logic            valid, sop, eop;
    logic [wOut-1:0] d_real, d_imag;
    logic [11:0]     dftpts;
    modport ST_OUT (output valid, sop, eop, d_real, d_imag, dftpts);
    modport ST_IN  (input  valid, sop, eop, d_real, d_imag, dftpts);
endinterface

// File: rtl/divider_7.sv
// divider_7: quotient and remainder of a 12-bit address by 7 via reciprocal multiply, exact below 5461
module divider_7 (
    input  logic [11:0] a_i,
    output logic [7:0]  q_o,
    output logic [2:0]  r_o
);
    assign q_o = 8'((24'(a_i) * 24'd2341) >> 14);
    assign r_o = 3'(a_i - 12'(q_o) * 12'd7);
endmodule

// File: rtl/mrd_sync_fifo.sv
// mrd_sync_fifo: single-clock FIFO with occupancy count, power-of-2 depth
module mrd_sync_fifo #(
    parameter int W     = 38,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_i,
    input  logic [W-1:0] wdata_i,
    input  logic         rd_i,
    output logic [W-1:0] rdata_o,
    output logic [AW:0]  count_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_i) begin
                mem_q[wp_q] <= wdata_i;
                wp_q        <= wp_q + 1'b1;
            end
            if (rd_i) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(wr_i) - (AW+1)'(rd_i);
        end
    end

    assign rdata_o = mem_q[rp_q];
    assign count_o = cnt_q;
endmodule

// File: rtl/mrd_source_unload.sv
// mrd_source_unload: reads the finished DFT out of 7 banks in CRT output order and streams it with backpressure
module mrd_source_unload
    import mrd_pkg::*;
#(
    parameter int wBank      = 30,
    parameter int wOut       = 18,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [11:0]                          dftpts,
    input  logic [0:2][11:0]                     Nf_PFA,
    output logic [0:NUM_BANKS-1]                 bank_rden,
    output logic [0:NUM_BANKS-1][BANK_AW-1:0]    bank_rdaddr,
    input  logic [0:NUM_BANKS-1][wBank-1:0]      bank_dout_real,
    input  logic [0:NUM_BANKS-1][wBank-1:0]      bank_dout_imag,
    mrd_st_if.ST_OUT                             out_data,
    input  logic                                 source_ready,
    output logic                                 source_ongoing
);
    localparam int CW = $clog2(FIFO_DEPTH);
    localparam int EW = 2 * wOut + 2;

    src_state_e       state_q, state_d;
    logic [11:0]      pts_q, n1_q, n2_q, n3_q, n23_q;
    logic [11:0]      k_q, k1_q, k2_q, k3_q, k_d, k1_d, k2_d, k3_d;
    logic             issue, last, valid, xfer;
    logic             s1_v_q, s2_v_q, s3_v_q;
    logic [1:0]       s1_fl_q, s2_fl_q, s3_fl_q;
    logic [11:0]      a_q;
    logic [7:0]       div_q;
    logic [2:0]       div_r, s2_bank_q, s3_bank_q;
    logic [BANK_AW-1:0] addr_q;
    logic [CW:0]      fifo_cnt;
    logic [EW-1:0]    fifo_din, fifo_dout;
    logic [wOut-1:0]  sat_re, sat_im;

    // credit covers everything already issued but not yet written, so the FIFO cannot overflow
    always_comb begin
        last    = k_q == pts_q - 12'd1;
        valid   = fifo_cnt != '0;
        xfer    = valid && source_ready;
        issue   = state_q == ST_ISSUE &&
                  (int'(fifo_cnt) + int'(s1_v_q) + int'(s2_v_q) + int'(s3_v_q) < FIFO_DEPTH);
        state_d = (state_q == ST_IDLE && start) ? ST_ISSUE :
                  (issue && last) ? ST_DRAIN :
                  (state_q == ST_DRAIN && xfer && fifo_dout[0] && fifo_cnt == 1 &&
                   !s1_v_q && !s2_v_q && !s3_v_q) ? ST_IDLE : state_q;
        k_d     = (state_q == ST_IDLE) ? '0 : issue ? k_q + 12'd1 : k_q;
        k1_d    = (state_q == ST_IDLE) ? '0 : !issue ? k1_q : (k1_q == n1_q - 12'd1) ? '0 : k1_q + 12'd1;
        k2_d    = (state_q == ST_IDLE) ? '0 : !issue ? k2_q : (k2_q == n2_q - 12'd1) ? '0 : k2_q + 12'd1;
        k3_d    = (state_q == ST_IDLE) ? '0 : !issue ? k3_q : (k3_q == n3_q - 12'd1) ? '0 : k3_q + 12'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            k1_q    <= '0;
            k2_q    <= '0;
            k3_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            k1_q    <= k1_d;
            k2_q    <= k2_d;
            k3_q    <= k3_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pts_q <= '0;
            n1_q  <= '0;
            n2_q  <= '0;
            n3_q  <= '0;
            n23_q <= '0;
        end else if (state_q == ST_IDLE && start) begin
            pts_q <= dftpts;
            n1_q  <= Nf_PFA[0];
            n2_q  <= Nf_PFA[1];
            n3_q  <= Nf_PFA[2];
            n23_q <= Nf_PFA[1] * Nf_PFA[2];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {s1_v_q, s2_v_q, s3_v_q}    <= '0;
            {s1_fl_q, s2_fl_q, s3_fl_q} <= '0;
            a_q       <= '0;
            addr_q    <= '0;
            s2_bank_q <= '0;
            s3_bank_q <= '0;
        end else begin
            s1_v_q    <= issue;
            s1_fl_q   <= {issue && k_q == '0, issue && last};
            a_q       <= k1_q * n23_q + k2_q * n3_q + k3_q;
            s2_v_q    <= s1_v_q;
            s2_fl_q   <= s1_fl_q;
            s2_bank_q <= div_r;
            addr_q    <= div_q;
            s3_v_q    <= s2_v_q;
            s3_fl_q   <= s2_fl_q;
            s3_bank_q <= s2_bank_q;
        end
    end

    divider_7 u_div (.a_i(a_q), .q_o(div_q), .r_o(div_r));

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        assign bank_rden[i]   = s2_v_q && s2_bank_q == 3'(i);
        assign bank_rdaddr[i] = addr_q;
    end

    assign sat_re   = wOut'(sat(64'(signed'(bank_dout_real[s3_bank_q])), wOut));
    assign sat_im   = wOut'(sat(64'(signed'(bank_dout_imag[s3_bank_q])), wOut));
    assign fifo_din = {sat_re, sat_im, s3_fl_q};

    mrd_sync_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk, .rst_n,
        .wr_i(s3_v_q), .wdata_i(fifo_din),
        .rd_i(xfer), .rdata_o(fifo_dout),
        .count_o(fifo_cnt)
    );

    assign out_data.valid  = valid;
    assign out_data.sop    = valid && fifo_dout[1];
    assign out_data.eop    = valid && fifo_dout[0];
    assign out_data.d_real = valid ? fifo_dout[EW-1 -: wOut] : '0;
    assign out_data.d_imag = valid ? fifo_dout[2 +: wOut] : '0;
    assign out_data.dftpts = pts_q;
    assign source_ongoing  = state_q != ST_IDLE;
endmodule

// File: tb/tb_mrd_source_unload.sv
// tb_mrd_source_unload: random-data bench against a CRT-order frame model with bank memory model
module tb_mrd_source_unload;
    logic clk = 0;
    always #5 clk = ~clk;

    logic              rst_n, start, source_ready, source_ongoing;
    logic [11:0]       dftpts;
    logic [0:2][11:0]  nf;
    logic [0:6]        rden;
    logic [0:6][7:0]   raddr;
    logic [0:6][29:0]  dr, di;

    mrd_st_if #(.wOut(18)) so ();

    mrd_source_unload #(.wBank(30), .wOut(18), .FIFO_DEPTH(8)) dut (
        .clk, .rst_n, .start, .dftpts, .Nf_PFA(nf),
        .bank_rden(rden), .bank_rdaddr(raddr),
        .bank_dout_real(dr), .bank_dout_imag(di),
        .out_data(so), .source_ready, .source_ongoing
    );

    logic signed [29:0] mem_r [7][256];
    logic signed [29:0] mem_i [7][256];

    always @(posedge clk)
        for (int b = 0; b < 7; b++)
            if (rden[b]) begin
                dr[b] <= mem_r[b][raddr[b]];
                di[b] <= mem_i[b][raddr[b]];
            end

    int n_cmp = 0, n_bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int f_pts = 0, f_n1 = 1, f_n2 = 1, f_n3 = 1, exp_k = 0, reads = 0;
    int first_rden = -1, first_valid = -1, last_cyc = -1, start_cyc = 0;
    int rd_b[$], rd_a[$];
    logic signed [17:0] got_r [1792];
    logic stall_p = 0, eop_p = 0, p_sop, p_eop;
    logic [17:0] p_re, p_im;

    function automatic longint satv(input longint v);
        return (v > 131071) ? 131071 : (v < -131072) ? -131072 : v;
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, req);
        end
    endtask

    always @(negedge clk) begin
        int rc, a;
        if (!rst_n) begin
            stall_p = 0;
            eop_p   = 0;
        end else begin
            rc = 0;
            for (int b = 0; b < 7; b++)
                if (rden[b]) begin
                    rc++;
                    reads++;
                    rd_b.push_back(b);
                    rd_a.push_back(int'(raddr[b]));
                    if (first_rden < 0) first_rden = cyc;
                end
            if (rc > 0) chk("rden_onehot", rc, 1);
            if (so.valid && first_valid < 0) first_valid = cyc;
            if (stall_p) begin
                chk("hold_valid", so.valid, 1);
                chk("hold_re", so.d_real, p_re);
                chk("hold_im", so.d_imag, p_im);
                chk("hold_sop", so.sop, p_sop);
                chk("hold_eop", so.eop, p_eop);
            end
            if (eop_p) chk("ongoing_fall", source_ongoing, 0);
            if (so.valid && source_ready) begin
                if (exp_k < f_pts) begin
                    a = (exp_k % f_n1) * f_n2 * f_n3 + (exp_k % f_n2) * f_n3 + exp_k % f_n3;
                    chk("beat_re", $signed(so.d_real), satv(mem_r[a % 7][a / 7]));
                    chk("beat_im", $signed(so.d_imag), satv(mem_i[a % 7][a / 7]));
                    chk("beat_sop", so.sop, exp_k == 0);
                    chk("beat_eop", so.eop, exp_k == f_pts - 1);
                    chk("beat_pts", so.dftpts, f_pts);
                    chk("beat_ongoing", source_ongoing, 1);
                    got_r[exp_k] = so.d_real;
                    if (exp_k == f_pts - 1) last_cyc = cyc;
                    exp_k++;
                end else
                    chk("extra_beat", so.valid, 0);
            end
            eop_p   = so.valid && source_ready && so.eop;
            stall_p = so.valid && !source_ready;
            p_re = so.d_real; p_im = so.d_imag; p_sop = so.sop; p_eop = so.eop;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int mode);
        for (int a = 0; a < 1792; a++) begin
            mem_r[a % 7][a / 7] = (mode == 0) ? 30'(a) : (mode == 1) ? 30'(int'($urandom) >>> $urandom_range(12, 16)) : '0;
            mem_i[a % 7][a / 7] = (mode == 0) ? 30'(-a) : (mode == 1) ? 30'(int'($urandom) >>> $urandom_range(12, 16)) : '0;
        end
        if (mode == 2) begin
            mem_r[0][0] = 30'sd1048576;  mem_i[0][0] = 30'sd131071;
            mem_r[1][0] = -30'sd1048576; mem_i[1][0] = -30'sd131072;
            mem_r[2][0] = 30'sd131071;   mem_i[2][0] = 30'sd1048576;
            mem_r[3][0] = -30'sd131072;  mem_i[3][0] = -30'sd1048576;
        end
    endtask

    task automatic begin_frame(input int pts, input int n1, input int n2, input int n3);
        f_pts = pts; f_n1 = n1; f_n2 = n2; f_n3 = n3;
        exp_k = 0; reads = 0; first_rden = -1; first_valid = -1; last_cyc = -1;
        rd_b.delete(); rd_a.delete();
        start = 1; dftpts = 12'(pts); nf = {12'(n1), 12'(n2), 12'(n3)};
        start_cyc = cyc;
        tick();
        start = 0; dftpts = '0; nf = '0;
    endtask

    task automatic wait_frame(input int pts, input int duty, input int stall);
        int c = 0;
        while (!(exp_k == pts && !source_ongoing) && c < 20 * pts + 200) begin
            if (stall > 0 && c == stall) begin
                chk("stall_reads", reads, 8);
                chk("stall_valid", so.valid, 1);
            end
            source_ready = (c < stall) ? 1'b0 : ($urandom_range(99) < duty);
            tick();
            c++;
        end
        chk("frame_done", exp_k, pts);
        chk("frame_idle", source_ongoing, 0);
    endtask

    task automatic run_frame(input int pts, input int n1, input int n2, input int n3, input int duty, input int stall);
        begin_frame(pts, n1, n2, n3);
        wait_frame(pts, duty, stall);
    endtask

    initial begin
        rst_n = 0; start = 0; source_ready = 0; dftpts = '0; nf = '0;
        repeat (3) tick();
        chk("rst_valid", so.valid, 0);
        chk("rst_rden", rden, 0);
        chk("rst_addr", raddr, 0);
        chk("rst_ongoing", source_ongoing, 0);
        chk("rst_dreal", so.d_real, 0);
        chk("rst_pts", so.dftpts, 0);
        rst_n = 1;
        source_ready = 1;
        tick();

        fill(0);
        run_frame(12, 4, 3, 1, 100, 0);
        chk("f1_rden_lat", first_rden - start_cyc, 3);
        chk("f1_valid_lat", first_valid - start_cyc, 5);
        chk("f1_last_lat", last_cyc - start_cyc, 16);
        chk("f1_reads", reads, 12);
        chk("f1_k5_data", got_r[5], 5);
        chk("f1_k5_bank", rd_b[5], 5);
        chk("f1_k5_addr", rd_a[5], 0);
        chk("f1_k7_data", got_r[7], 10);
        chk("f1_k7_bank", rd_b[7], 3);
        chk("f1_k7_addr", rd_a[7], 1);

        fill(2);
        run_frame(4, 4, 1, 1, 100, 0);
        chk("sat_pos", got_r[0], 131071);
        chk("sat_neg", got_r[1], -131072);
        chk("sat_max", got_r[2], 131071);
        chk("sat_min", got_r[3], -131072);

        fill(1);
        run_frame(1200, 16, 3, 25, 30, 0);
        chk("big_reads", reads, 1200);

        run_frame(1, 1, 1, 1, 100, 0);
        chk("one_reads", reads, 1);
        chk("one_bank", rd_b[0], 0);
        chk("one_addr", rd_a[0], 0);

        fill(0);
        source_ready = 1;
        begin_frame(60, 4, 3, 5);
        repeat (10) tick();
        start = 1; dftpts = 12'd5; nf = {12'd5, 12'd1, 12'd1};
        tick();
        start = 0; dftpts = '0; nf = '0;
        repeat (10) tick();
        chk("restart_ignored_prog", exp_k >= 10, 1);
        chk("restart_ongoing", source_ongoing, 1);
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("midrst_valid", so.valid, 0);
        chk("midrst_ongoing", source_ongoing, 0);
        chk("midrst_rden", rden, 0);
        repeat (3) tick();
        chk("midrst_quiet", so.valid, 0);
        run_frame(60, 4, 3, 5, 70, 0);

        fill(1);
        source_ready = 0;
        run_frame(100, 4, 25, 1, 60, 50);
        chk("stall_total_reads", reads, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mrd_source_unload.md
# mrd_source_unload

Source-side unloader for the Mixed Radix DFT memory. After the last butterfly stage it reads the finished DFT result out of the 7 interleaved RAM banks in natural output order (CRT output mapping over the PFA factors N1·N2·N3). It streams the result on the ST_OUT source interface with sop/eop framing and downstream backpressure, and it reports `source_ongoing` to the controller.

## Interface
- `wBank`, 30: bank read-data width, signed.
- `wOut`, 18: output sample width, signed.
- `FIFO_DEPTH`, 8: output FIFO entries, power of 2, ≥ 5.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle pulse from ctrl on entry to the source state.
- `dftpts` in 12: frame length, latched at `start`, 1..1792, equals N1·N2·N3.
- `Nf_PFA` in [0:2][11:0]: N1, N2, N3, latched at `start`, pairwise coprime, each ≥ 1.
- `bank_rden` out [0:6]: per-bank read enable.
- `bank_rdaddr` out [0:6][7:0]: per-bank read address.
- `bank_dout_real`, `bank_dout_imag` in [0:6][wBank-1:0]: bank read data, valid 1 cycle after `bank_rden`.
- `out_data` mrd_st_if.ST_OUT: fields `valid`, `sop`, `eop`, `d_real`/`d_imag` [wOut-1:0], `dftpts`.
- `source_ready` in 1: downstream accepts a beat.
- `source_ongoing` out 1: frame unload in progress.

## Operation
- States: IDLE, ISSUE, DRAIN.
  - IDLE→ISSUE on `start`. Latch dftpts and Nf_PFA, clear k=0, k1=k2=k3=0.
  - ISSUE: issue one read per cycle when `fifo_count + inflight < FIFO_DEPTH`, otherwise hold. After issuing k=dftpts-1 → DRAIN.
  - DRAIN: no issue. → IDLE when inflight=0, FIFO empty, and the eop beat has transferred.
- `start` is ignored outside IDLE.
- Index counters per issue: k++, k1=(k1+1) mod N1, k2=(k2+1) mod N2, k3=(k3+1) mod N3. Wrap uses compare-and-clear; no division.
- Memory address A = k1·N2·N3 + k2·N3 + k3, 12 bits, exact (A < dftpts).
- Bank mapping: bank = A mod 7, addr = A div 7 (addr 8 bits). Exactly one bank read per issue; all other `bank_rden` = 0.
- The selected bank's data is muxed using bank index delayed to the data cycle.
- Saturation: wBank→wOut signed clamp to [-2^(wOut-1), 2^(wOut-1)-1], i.e. [-131072, 131071] for 18 bits.
- FIFO entry holds {real, imag, sop, eop}. sop is set for k=0, eop for k=dftpts-1. dftpts=1 sets both on one beat.
- Output: `out_data.valid` = FIFO non-empty, independent of `source_ready`. A beat transfers when valid && source_ready. The head entry is held stable while !source_ready. `out_data.dftpts` = latched value.
- `source_ongoing` = state≠IDLE.

## Timing
- Pipeline, one stage per cycle: S0 counters → S1 A register → S2 divide-by-7 and register rden/rdaddr/bank_idx → S3 bank data → S4 saturate and FIFO write.
- `start` at cycle t with ready high: bank_rden at t+3, first valid at t+5.
- Throughput is 1 beat/cycle. Last beat at t+4+dftpts. `source_ongoing` falls the cycle after the eop transfer.
- `inflight` = valid count of S1..S4. With the credit rule, the FIFO never overflows under any ready pattern.
- FIFO simultaneous write and read with count=FIFO_DEPTH-1 or 0 leaves count unchanged. A read on empty never occurs.
- Reset values:
  - all outputs 0;
  - FIFO empty, state IDLE, counters 0.
- Reset mid-frame discards all in-flight data; no eop is emitted.

## Structure
- Shared package `mrd_pkg`: NUM_BANKS=7, BANK_AW=8, DFT_MAXPTS=1792, the state enum, and the saturation function.
- Sub-module `mrd_sync_fifo` (parameterised width/depth, count output), reusable on the sink side.
- Reuse the existing `divider_7` for A→bank/addr.

## Test plan
- dftpts=12, N=(4,3,1), ready=1, each bank word preloaded with its A:
  - out k=5 reads A=5 (bank 5, addr 0);
  - k=7 reads A=10 (bank 3, addr 1);
  - 12 consecutive beats, sop on beat 0, eop on beat 11, first valid at start+5.
- dftpts=1200, N=(16,3,25), random ready at 30% duty: all 1200 beats in order, no drops or duplicates, data held stable during stalls, `source_ongoing` falls after eop.
- Saturation: bank values 2^20, -2^20, 131071, -131072 → 131071, -131072, 131071, -131072.
- dftpts=1, N=(1,1,1): a single beat with sop=eop=1, reading bank 0 addr 0.
- A second `start` mid-frame is ignored. Then `rst_n`=0 for 1 cycle mid-frame: valid=0 next cycle, a new start yields a clean frame from k=0.
- ready=0 for 50 cycles after start: at most FIFO_DEPTH reads issued; the FIFO holds 8 entries, and after ready returns the full frame is intact.
